// File: rtl/dlo_ctrl_pkg.sv
// Shared types and default sizing for the dual-rail (DLO) evaluate sequencer.
package dlo_ctrl_pkg;

  localparam int W_DEF       = 8;
  localparam int PRE_CYC_DEF = 2;
  localparam int TMO_DEF     = 15;
  localparam int CNT_W       = 8;
  localparam int PRE_CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    EVAL = 2'd2,
    RESP = 2'd3
  } state_e;

endpackage

// File: rtl/dlo_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester that did not win the last grant wins.
module dlo_rr_arb2 (
  input  logic       CP,
  input  logic       CDN,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o
);

  logic prio_q, prio_d;

  always_comb begin
    gnt_id_o = 1'b0;
    if (req_i == 2'b11) begin
      gnt_id_o = prio_q;
    end else if (req_i[1]) begin
      gnt_id_o = 1'b1;
    end
    gnt_o = 2'b00;
    if (req_i != 2'b00) begin
      gnt_o = gnt_id_o ? 2'b10 : 2'b01;
    end
    prio_d = prio_q;
    if (adv_i && (req_i != 2'b00)) begin
      prio_d = ~gnt_id_o;
    end
  end

  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/dlo_eval_sequencer.sv
// Precharge/evaluate sequencer for a W-slice dual-rail DLO datapath shared by two requesters.
module dlo_eval_sequencer
  import dlo_ctrl_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int PRE_CYC = PRE_CYC_DEF,
  parameter int TMO     = TMO_DEF
) (
  input  logic           CP,
  input  logic           CDN,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [2*W-1:0] req_a,
  input  logic [2*W-1:0] req_b,
  output logic           dlo_en,
  output logic [W-1:0]   dlo_a,
  output logic [W-1:0]   dlo_b,
  input  logic [W-1:0]   dlo_z1,
  input  logic [W-1:0]   dlo_z2,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [W-1:0]   rsp_data,
  output logic           rsp_id,
  output logic           rsp_err
);

  localparam logic [PRE_CNT_W-1:0] PRE_LAST = PRE_CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0]     TMO_LAST = CNT_W'(TMO - 1);

  // Reset asserts immediately but deasserts on a clock edge, so no flop sees a runt release.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  state_e                 state_q, state_d;
  logic [PRE_CNT_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0]       eval_cnt_q, eval_cnt_d;
  logic [W-1:0]           a_q, a_d, b_q, b_d;
  logic [W-1:0]           data_q, data_d;
  logic                   id_q, id_d;
  logic                   err_q, err_d;
  logic                   dlo_en_q, dlo_en_d;
  logic                   rsp_valid_q, rsp_valid_d;

  logic [1:0]             gnt;
  logic                   gnt_id;
  logic                   arb_adv;

  dlo_rr_arb2 u_arb (
    .CP       (CP),
    .CDN      (rst_n),
    .req_i    (req_valid),
    .adv_i    (arb_adv),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  // A slice has resolved when its rails differ; both rails high is an illegal cell state.
  logic [W-1:0] bit_done;
  logic [W-1:0] bit_clash;
  logic         word_done;
  logic         any_clash;

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign bit_done[gi]  = dlo_z1[gi] ^ dlo_z2[gi];
    assign bit_clash[gi] = dlo_z1[gi] & dlo_z2[gi];
  end

  assign word_done = &bit_done;
  assign any_clash = |bit_clash;

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    eval_cnt_d = eval_cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    id_d       = id_q;
    data_d     = data_q;
    err_d      = err_q;
    req_ready  = 2'b00;
    arb_adv    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rst_n && (gnt != 2'b00)) begin
          req_ready = gnt;
          arb_adv   = 1'b1;
          a_d       = gnt_id ? req_a[2*W-1:W] : req_a[W-1:0];
          b_d       = gnt_id ? req_b[2*W-1:W] : req_b[W-1:0];
          id_d      = gnt_id;
          pre_cnt_d = '0;
          state_d   = PRE;
        end
      end
      PRE: begin
        if (pre_cnt_q == PRE_LAST) begin
          eval_cnt_d = '0;
          state_d    = EVAL;
        end else begin
          pre_cnt_d = pre_cnt_q + 1'b1;
        end
      end
      EVAL: begin
        eval_cnt_d = eval_cnt_q + 1'b1;
        // A rail clash outranks a completed word; a timeout only fires if nothing resolved.
        if (any_clash || (!word_done && (eval_cnt_q == TMO_LAST))) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (word_done) begin
          data_d  = dlo_z1;
          err_d   = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    dlo_en_d    = (state_d == EVAL);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge CP or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pre_cnt_q   <= '0;
      eval_cnt_q  <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      data_q      <= '0;
      err_q       <= 1'b0;
      dlo_en_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      eval_cnt_q  <= eval_cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      data_q      <= data_d;
      err_q       <= err_d;
      dlo_en_q    <= dlo_en_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign dlo_en    = dlo_en_q;
  assign dlo_a     = a_q;
  assign dlo_b     = b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dlo_eval_sequencer.sv
// Randomised bench for dlo_eval_sequencer with a behavioural XOR dual-rail cell model.
module tb_dlo_eval_sequencer;

  localparam int W   = 8;
  localparam int PRE = 2;
  localparam int TMO = 15;

  logic           CP = 1'b0;
  logic           CDN = 1'b0;
  logic [1:0]     req_valid = 2'b00;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_a = '0;
  logic [2*W-1:0] req_b = '0;
  logic           dlo_en;
  logic [W-1:0]   dlo_a, dlo_b;
  logic [W-1:0]   dlo_z1 = '0;
  logic [W-1:0]   dlo_z2 = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [W-1:0]   rsp_data;
  logic           rsp_id;
  logic           rsp_err;

  dlo_eval_sequencer #(.W(W), .PRE_CYC(PRE), .TMO(TMO)) dut (
    .CP        (CP),
    .CDN       (CDN),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .dlo_en    (dlo_en),
    .dlo_a     (dlo_a),
    .dlo_b     (dlo_b),
    .dlo_z1    (dlo_z1),
    .dlo_z2    (dlo_z2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err)
  );

  always #5 CP = ~CP;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Cell model: 0 = resolves on EVAL cycle cell_k, 1 = never resolves,
  // 2 = rail clash on bit cell_bit in EVAL cycle cell_k. Slice 0 stays unresolved until then.
  int cell_mode = 0;
  int cell_k    = 1;
  int cell_bit  = 0;
  int ecnt      = 0;

  always @(posedge CP) begin
    logic [W-1:0] x, m;
    #1;
    if (dlo_en === 1'b1) ecnt++;
    else ecnt = 0;
    x = dlo_a ^ dlo_b;
    m = W'($urandom) & ~W'(1);
    if (ecnt == 0) begin
      dlo_z1 = '0;
      dlo_z2 = '0;
    end else if ((cell_mode == 0) && (ecnt >= cell_k)) begin
      dlo_z1 = x;
      dlo_z2 = ~x;
    end else if ((cell_mode == 2) && (ecnt == cell_k)) begin
      dlo_z1 = x;
      dlo_z2 = ~x;
      dlo_z1[cell_bit] = 1'b1;
      dlo_z2[cell_bit] = 1'b1;
    end else begin
      dlo_z1 = x & m;
      dlo_z2 = ~x & m;
    end
  end

  int last_gnt = 1;

  task automatic run_job(input logic [1:0] vmask, input logic [W-1:0] a0, input logic [W-1:0] b0,
                         input logic [W-1:0] a1, input logic [W-1:0] b1,
                         input int mode, input int k, input int ebit, input int hold);
    int win, lat_exp, cyc, pre_zeros;
    bit seen_en, done;
    logic [W-1:0] ea, eb, edata;
    logic eerr;
    logic [1:0] exp_rdy;

    win = (vmask == 2'b11) ? (1 - last_gnt) : ((vmask == 2'b10) ? 1 : 0);
    ea = win ? a1 : a0;
    eb = win ? b1 : b0;
    if ((mode == 0) && (k <= TMO)) begin
      edata = ea ^ eb; eerr = 1'b0; lat_exp = PRE + 1 + k;
    end else if ((mode == 2) && (k <= TMO)) begin
      edata = '0; eerr = 1'b1; lat_exp = PRE + 1 + k;
    end else begin
      edata = '0; eerr = 1'b1; lat_exp = PRE + 1 + TMO;
    end
    cell_mode = mode; cell_k = k; cell_bit = ebit;
    exp_rdy = (win == 1) ? 2'b10 : 2'b01;

    @(negedge CP);
    req_valid = vmask;
    req_a = {a1, a0};
    req_b = {b1, b0};
    #1;
    cyc = 0;
    while ((req_ready == 2'b00) && (cyc < 20)) begin
      @(negedge CP); #1; cyc++;
    end
    check_eq("grant", 32'(req_ready), 32'(exp_rdy));
    if (req_ready == 2'b00) begin
      req_valid = 2'b00;
      return;
    end
    @(posedge CP); #1;
    req_valid = 2'b00;
    last_gnt = win;

    pre_zeros = 0; seen_en = 0; done = 0; cyc = 0;
    while (!done && (cyc < 60)) begin
      @(negedge CP); cyc++;
      if (rsp_valid === 1'b1) begin
        done = 1;
      end else if (dlo_en === 1'b1) begin
        if (!seen_en) begin
          seen_en = 1;
          check_eq("pre_len", 32'(pre_zeros), 32'(PRE));
          check_eq("dlo_a", 32'(dlo_a), 32'(ea));
          check_eq("dlo_b", 32'(dlo_b), 32'(eb));
        end
      end else if (!seen_en) begin
        pre_zeros++;
      end
    end
    check_eq("latency", 32'(cyc), 32'(lat_exp));
    if (!done) return;

    req_valid = 2'b11;
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge CP);
      #1;
      check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("rsp_data", 32'(rsp_data), 32'(edata));
      check_eq("rsp_id", 32'(rsp_id), 32'(win));
      check_eq("rsp_err", 32'(rsp_err), 32'(eerr));
      check_eq("hold_ready", 32'(req_ready), 32'd0);
      check_eq("hold_en", 32'(dlo_en), 32'd0);
    end
    rsp_ready = 1'b1;
    req_valid = 2'b00;
    @(negedge CP); #1;
    rsp_ready = 1'b0;
    check_eq("rsp_drop", 32'(rsp_valid), 32'd0);
    check_eq("idle_en", 32'(dlo_en), 32'd0);
    $display("job vmask=%0d id=%0d mode=%0d k=%0d lat=%0d data=%02h err=%0d", vmask, win, mode, k,
             cyc, rsp_data, rsp_err);
  endtask

  initial begin
    int cyc;
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    // Reset state, with both requesters asserting valid
    req_valid = 2'b11;
    #12;
    check_eq("rst_en", 32'(dlo_en), 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_data", 32'(rsp_data), 32'd0);
    check_eq("rst_id", 32'(rsp_id), 32'd0);
    check_eq("rst_err", 32'(rsp_err), 32'd0);
    check_eq("rst_a", 32'(dlo_a), 32'd0);
    check_eq("rst_b", 32'(dlo_b), 32'd0);
    req_valid = 2'b00;
    @(negedge CP); CDN = 1'b1;
    repeat (3) @(negedge CP);

    // Tie on three consecutive jobs: grants alternate 0,1,0
    for (int j = 0; j < 3; j++)
      run_job(2'b11, 8'h11, 8'h22, 8'h33, 8'h44, 0, 2, 0, 0);

    run_job(2'b01, 8'h5A, 8'h0F, 8'h00, 8'h00, 0, 3, 0, 0);
    run_job(2'b01, 8'hA5, 8'h3C, 8'h00, 8'h00, 1, 0, 0, 0);
    run_job(2'b10, 8'h00, 8'h00, 8'hC3, 8'h81, 2, 1, 3, 0);
    run_job(2'b10, 8'h00, 8'h00, 8'h7E, 8'h18, 0, 1, 0, 10);
    run_job(2'b01, 8'hF0, 8'h0F, 8'h00, 8'h00, 0, TMO, 0, 1);

    // Reset pulsed while evaluating: outputs drop at once, job is abandoned
    cell_mode = 1;
    @(negedge CP);
    req_valid = 2'b10; req_a = {8'h12, 8'h34}; req_b = {8'h56, 8'h78};
    cyc = 0;
    while ((dlo_en !== 1'b1) && (cyc < 20)) begin
      @(negedge CP); cyc++;
      req_valid = 2'b00;
    end
    check_eq("mid_eval_reached", 32'(dlo_en), 32'd1);
    req_valid = 2'b00;
    #2 CDN = 1'b0;
    #1;
    check_eq("mid_rst_en", 32'(dlo_en), 32'd0);
    check_eq("mid_rst_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(negedge CP);
    CDN = 1'b1;
    repeat (3) @(negedge CP);
    check_eq("post_rst_valid", 32'(rsp_valid), 32'd0);
    last_gnt = 1;
    run_job(2'b11, 8'h01, 8'h02, 8'h03, 8'h04, 0, 1, 0, 0);

    for (int j = 0; j < 30; j++) begin
      logic [1:0] vm;
      int md, kk;
      vm = 2'($urandom_range(1, 3));
      md = $urandom_range(0, 2);
      kk = (md == 1) ? 0 : $urandom_range(1, TMO + 2);
      run_job(vm, W'($urandom), W'($urandom), W'($urandom), W'($urandom), md, kk,
              $urandom_range(0, W - 1), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dlo_eval_sequencer.md
DLO_EVAL_SEQUENCER -- requirements
Module: dlo_eval_sequencer

Interface
REQ-001 Parameter W, default 8: datapath width in bits (W DLO cell slices).
REQ-002 Parameter PRE_CYC, default 2: precharge cycles before each evaluate (legal 1..15).
REQ-003 Parameter TMO, default 15: max evaluate cycles before timeout (legal 1..255).
REQ-004 CP  in  1  clock, rising-edge; the one clock of the block.
REQ-005 CDN  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  2  per-requester operand-valid.
REQ-007 req_ready  out  2  per-requester accept; a transfer occurs when valid&ready in the same cycle.
REQ-008 req_a, req_b  in  2*W each  operands; requester i occupies bits [i*W +: W].
REQ-009 dlo_en  out  1  evaluate enable to the cells' CP pin (0 = precharge, 1 = evaluate).
REQ-010 dlo_a, dlo_b  out  W each  latched operands to the cells' A/B pins.
REQ-011 dlo_z1, dlo_z2  in  W each  complementary dual-rail results from the cells.
REQ-012 rsp_valid  out  1; rsp_ready  in  1: response handshake.
REQ-013 rsp_data  out  W  result (dlo_z1 at completion); rsp_id  out  1  granted requester; rsp_err  out  1  error flag.

Function
REQ-014 FSM states IDLE, PRE, EVAL, RESP; reset state IDLE.
REQ-015 IDLE: req_ready is one-hot to the arbiter grant when any req_valid=1, else 0; all other states: req_ready=0.
REQ-016 Arbitration round-robin over 2: the requester not granted last wins a tie; pointer after reset favours requester 0.
REQ-017 On transfer: latch operands into dlo_a/dlo_b and grant into rsp_id; go to PRE next cycle.
REQ-018 PRE: dlo_en=0 for exactly PRE_CYC cycles; then EVAL.
REQ-019 EVAL: dlo_en=1; a bit is complete when z1^z2=1; word complete when all W bits complete.
REQ-020 Word complete in an EVAL cycle: next cycle RESP with rsp_data=dlo_z1 sampled that cycle, rsp_err=0, dlo_en=0.
REQ-021 Any bit with z1&z2=1 in EVAL: next cycle RESP with rsp_err=1, rsp_data=0 (error has priority over completion).
REQ-022 Evaluate counter 8 bits, cleared on entering EVAL; if no completion after TMO EVAL cycles: RESP with rsp_err=1, rsp_data=0.
REQ-023 Minimum accept-to-rsp_valid latency = PRE_CYC+2 cycles; maximum = PRE_CYC+TMO+1.
REQ-024 RESP: rsp_valid=1; rsp_data/rsp_id/rsp_err held stable until rsp_ready=1; then IDLE next cycle (one idle cycle between jobs).
REQ-025 dlo_en is a registered output, glitch-free; it is 1 only in EVAL.
REQ-026 dlo_a/dlo_b hold their last value outside PRE/EVAL.
REQ-027 z1/z2 are ignored outside EVAL.

Reset
REQ-028 CDN=0 asynchronously forces: state IDLE, dlo_en=0, req_ready=0, rsp_valid=0, rsp_err=0, rsp_id=0, rsp_data=0, dlo_a=0, dlo_b=0, counters=0, RR pointer favouring requester 0.
REQ-029 Reset mid-operation abandons the job with no response; release is synchronised so the first post-reset edge sees IDLE.

Structure
REQ-030 Package dlo_ctrl_pkg holds the FSM state enum, default parameter values and the counter width constant.
REQ-031 Sub-module dlo_rr_arb2 (2-way round-robin arbiter with CP/CDN) provides the grant; completion detect is inline.

Verification (W=8, PRE_CYC=2, TMO=15, cell model = XOR_DLO precharge/evaluate)
REQ-032 Port0 a=0x5A b=0x0F, model completes 3 cycles into EVAL -> rsp_data=0x55, rsp_id=0, rsp_err=0, dlo_en low for 2 cycles before evaluate.
REQ-033 Both req_valid=1 for three jobs -> grants 0,1,0; req_ready never two-hot.
REQ-034 Model never completes -> rsp_valid after 15 EVAL cycles, rsp_err=1, rsp_data=0x00.
REQ-035 Model drives z1[3]=z2[3]=1 in the first EVAL cycle -> RESP next cycle, rsp_err=1.
REQ-036 rsp_ready held 0 for 10 cycles -> response stable, req_ready=0, dlo_en=0 throughout.
REQ-037 CDN pulsed low during EVAL -> dlo_en and rsp_valid 0 immediately; the next job is granted to requester 0.
